// File: rtl/univ_shift_register.sv
// Universal shift register: single-cycle hold/load/shift/rotate/ASR/clear plus
// multi-step shift/rotate sequences that move one bit per enabled clock.
module univ_shift_register #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [2:0]         mode,
    input  logic [WIDTH-1:0]   d,
    input  logic               ser_in,
    input  logic               start,
    input  logic [SHAMT_W-1:0] amount,
    output logic [WIDTH-1:0]   q,
    output logic               ser_out_msb,
    output logic               ser_out_lsb,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_n;
    logic [2:0]         op_r, op_n;
    logic [SHAMT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0]   q_n;
    logic               busy_n, done_n;
    logic               seq_mode;

    // One step of any operation applied to the current contents.
    function automatic logic [WIDTH-1:0] step_q(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic             si,
        input logic [WIDTH-1:0] din
    );
        logic [WIDTH-1:0] r;
        case (op)
            M_HOLD:  r = cur;
            M_LOAD:  r = din;
            M_SHL:   r = {cur[WIDTH-2:0], si};
            M_SHR:   r = {si, cur[WIDTH-1:1]};
            M_ROL:   r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROR:   r = {cur[0], cur[WIDTH-1:1]};
            M_ASR:   r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            M_CLR:   r = '0;
            default: r = cur;
        endcase
        return r;
    endfunction

    assign seq_mode    = (mode >= M_SHL) && (mode <= M_ASR);
    assign ser_out_msb = q[WIDTH-1];
    assign ser_out_lsb = q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_r  <= M_HOLD;
            cnt   <= '0;
            q     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            op_r  <= op_n;
            cnt   <= cnt_n;
            q     <= q_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // Next-state logic; en=0 leaves every register at its current value.
    always_comb begin
        state_n = state;
        op_n    = op_r;
        cnt_n   = cnt;
        q_n     = q;
        busy_n  = busy;
        done_n  = done;
        if (en) begin
            done_n = 1'b0;
            case (state)
                IDLE: begin
                    if (start && seq_mode) begin
                        op_n    = mode;
                        cnt_n   = amount;
                        busy_n  = 1'b1;
                        state_n = RUN;
                    end else begin
                        q_n    = step_q(mode, q, ser_in, d);
                        done_n = start;
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        q_n   = step_q(op_r, q, ser_in, d);
                        cnt_n = cnt - SHAMT_W'(1);
                    end else begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shift_register.sv
// Self-checking bench for univ_shift_register: directed cases plus randomized
// single steps and sequences checked against an arithmetic reference model.
module tb_univ_shift_register;

    localparam int unsigned W  = 8;
    localparam int unsigned SW = 4;

    logic          clk, rst_n, en, ser_in, start;
    logic [2:0]    mode;
    logic [W-1:0]  d, q;
    logic [SW-1:0] amount;
    logic          ser_out_msb, ser_out_lsb, busy, done;

    int checks   = 0;
    int failures = 0;

    univ_shift_register #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d),
        .ser_in(ser_in), .start(start), .amount(amount), .q(q),
        .ser_out_msb(ser_out_msb), .ser_out_lsb(ser_out_lsb),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: one step of any mode, in plain integer arithmetic.
    function automatic int ref_step(input int m, input int cur, input int si, input int din);
        int mask = (1 << W) - 1;
        case (m)
            0: return cur;
            1: return din;
            2: return ((cur << 1) | si) & mask;
            3: return (cur >> 1) | (si << (W - 1));
            4: return ((cur << 1) | (cur >> (W - 1))) & mask;
            5: return (cur >> 1) | ((cur & 1) << (W - 1));
            6: return (cur >> 1) | (cur & (1 << (W - 1)));
            default: return 0;
        endcase
    endfunction

    // Reference: closed-form result of an n-step sequence with constant ser_in.
    function automatic int ref_seq(input int m, input int cur, input int si, input int n);
        int mask = (1 << W) - 1;
        int fill = si ? mask : 0;
        int r    = n % W;
        int nn   = (n >= W) ? W : n;
        int sgn  = ((cur >> (W - 1)) & 1) ? mask : 0;
        case (m)
            2: return (n >= W) ? fill : (((cur << n) | (fill & ((1 << n) - 1))) & mask);
            3: return (n >= W) ? fill : ((cur >> n) | (fill & ~(mask >> n) & mask));
            4: return ((cur << r) | (cur >> (W - r))) & mask;
            5: return ((cur >> r) | (cur << (W - r))) & mask;
            6: return (cur >> nn) | (sgn & ~(mask >> nn) & mask);
            default: return cur;
        endcase
    endfunction

    task automatic do_step(input string tag, input logic [2:0] m, input logic si, input int exp);
        en = 1'b1; start = 1'b0; mode = m; ser_in = si;
        tick();
        check(tag, q, exp);
    endtask

    // Preload, start a sequence, optionally pause it, scramble ignored inputs,
    // and check busy length, final value and the single done pulse.
    task automatic run_seq(input string tag, input logic [2:0] m, input int n, input logic si,
                           input int pre, input int pause_at, input int pause_len, input int exp_q);
        int busy_cnt, c;
        logic [W-1:0] prev_q;
        en = 1'b1; start = 1'b0; mode = 3'b001; d = W'(pre);
        tick();
        mode = m; amount = SW'(n); ser_in = si; start = 1'b1;
        tick();
        check({tag, "_accept_busy"}, busy, 1);
        check({tag, "_accept_q"}, q, pre);
        busy_cnt = 1; c = 0; prev_q = q;
        while (busy && c < 200) begin
            en     = !(c >= pause_at && c < pause_at + pause_len);
            start  = 1'($urandom);
            mode   = 3'($urandom);
            d      = W'($urandom);
            amount = SW'($urandom);
            tick();
            if (!en) begin
                check({tag, "_pause_q"}, q, prev_q);
                check({tag, "_pause_busy"}, busy, 1);
            end
            prev_q = q;
            if (busy) busy_cnt++;
            c++;
        end
        check({tag, "_busy_len"}, busy_cnt, n + 1 + pause_len);
        check({tag, "_done"}, done, 1);
        check({tag, "_final_q"}, q, exp_q);
        en = 1'b1; start = 1'b0; mode = 3'b000;
        tick();
        check({tag, "_done_clear"}, done, 0);
        check({tag, "_hold_q"}, q, exp_q);
    endtask

    initial begin
        int mq, mdone, exp;
        logic [2:0] m;
        logic si;
        int n, pa, pl, pre;

        rst_n = 1'b0; en = 1'b0; mode = 3'b000; d = '0; ser_in = 1'b0;
        start = 1'b0; amount = '0;
        #12;
        check("reset_q", q, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;

        // Mid-cycle reset clears immediately
        en = 1'b1; mode = 3'b001; d = 8'hA5;
        tick();
        check("load_a5", q, 8'hA5);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_q", q, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        rst_n = 1'b1;
        mode = 3'b001; d = 8'h3C;
        tick();
        check("load_3c", q, 8'h3C);

        d = 8'h81; do_step("load_81", 3'b001, 1'b0, 8'h81);
        do_step("rol_81", 3'b100, 1'b0, 8'h03);
        check("ser_out_msb", ser_out_msb, 0);
        check("ser_out_lsb", ser_out_lsb, 1);
        do_step("ror_03", 3'b101, 1'b0, 8'h81);
        do_step("asr_81", 3'b110, 1'b0, 8'hC0);
        d = 8'h81; do_step("load_81b", 3'b001, 1'b0, 8'h81);
        do_step("shl_81", 3'b010, 1'b1, 8'h03);
        do_step("clr", 3'b111, 1'b0, 8'h00);

        // Single-step start gives immediate done without busy
        en = 1'b1; start = 1'b1; mode = 3'b001; d = 8'h77;
        tick();
        check("start_load_q", q, 8'h77);
        check("start_load_done", done, 1);
        check("start_load_busy", busy, 0);
        start = 1'b0; mode = 3'b000;
        tick();
        check("start_load_done_clr", done, 0);

        run_seq("ror3", 3'b101, 3, 1'b0, 8'h96, 0, 0, 8'hD2);
        run_seq("amt0", 3'b100, 0, 1'b0, 8'h3C, 0, 0, 8'h3C);
        run_seq("rol8", 3'b100, 8, 1'b0, 8'h5A, 0, 0, 8'h5A);
        run_seq("shr10", 3'b011, 10, 1'b0, 8'hFF, 0, 0, 8'h00);
        run_seq("shl_pause", 3'b010, 5, 1'b1, 8'h81, 2, 2, 8'h3F);

        // Reset during RUN aborts with no done
        en = 1'b1; start = 1'b0; mode = 3'b001; d = 8'hA5;
        tick();
        start = 1'b1; mode = 3'b100; amount = SW'(6);
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("abort_q", q, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        rst_n = 1'b1;
        mode = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done", done, 0);
        end

        // Back-to-back: start held through the done cycle
        mode = 3'b001; d = 8'h0F;
        tick();
        start = 1'b1; mode = 3'b100; amount = SW'(1);
        tick();
        check("b2b_busy1", busy, 1);
        amount = SW'(2);
        tick();
        tick();
        check("b2b_done1", done, 1);
        check("b2b_busy_low", busy, 0);
        check("b2b_q1", q, 8'h1E);
        tick();
        check("b2b_rebusy", busy, 1);
        check("b2b_done_clr", done, 0);
        start = 1'b0;
        tick();
        tick();
        tick();
        check("b2b_done2", done, 1);
        check("b2b_q2", q, 8'h78);
        mode = 3'b000;
        tick();

        // Randomized mix of single steps and sequences
        mode = 3'b001; d = 8'h5A; start = 1'b0; en = 1'b1;
        tick();
        mq = 8'h5A; mdone = 0;
        check("rand_seed_q", q, mq);
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) < 7) begin
                en     = ($urandom_range(0, 3) != 0);
                mode   = 3'($urandom);
                ser_in = 1'($urandom);
                d      = W'($urandom);
                amount = SW'($urandom);
                start  = (mode == 3'b000 || mode == 3'b001 || mode == 3'b111) ? 1'($urandom) : 1'b0;
                tick();
                if (en) begin
                    mq    = ref_step(int'(mode), mq, int'(ser_in), int'(d));
                    mdone = int'(start);
                end
                check("rand_q", q, mq);
                check("rand_done", done, mdone);
                check("rand_busy", busy, 0);
                check("rand_msb", ser_out_msb, (mq >> (W - 1)) & 1);
                check("rand_lsb", ser_out_lsb, mq & 1);
            end else begin
                m   = 3'($urandom_range(2, 6));
                n   = $urandom_range(0, 15);
                si  = 1'($urandom);
                pre = $urandom_range(0, 255);
                pa  = $urandom_range(0, n);
                pl  = $urandom_range(0, 2);
                exp = ref_seq(int'(m), pre, int'(si), n);
                run_seq("rand_seq", m, n, si, pre, pa, pl, exp);
                mq = exp; mdone = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/univ_shift_register.md
Name: univ_shift_register

Overview:
Parametrised universal register that generalises the team's fixed 8-bit D-register in three ways: configurable width, an asynchronous reset, and selectable modes (hold, load, shift, rotate, arithmetic shift, clear). Besides single-cycle operations, it runs multi-cycle shift/rotate sequences of a programmable step count, moving one bit per clock and reporting completion with busy/done. It is used as a general datapath register and serialiser/deserialiser in lab datapaths.

Parameters:
WIDTH, 8, register width in bits (WIDTH >= 2)
SHAMT_W, 4, width of the step-count input; 2**SHAMT_W - 1 >= WIDTH required

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  clock enable; 0 freezes all state, including an in-progress sequence
mode  input  3  operation select (encoding below)
d  input  WIDTH  parallel load data
ser_in  input  1  serial input bit for SHL/SHR
start  input  1  request multi-step sequence (sampled only in IDLE with en=1)
amount  input  SHAMT_W  step count for the sequence
q  output  WIDTH  register contents
ser_out_msb  output  1  equals q[WIDTH-1], combinational from q
ser_out_lsb  output  1  equals q[0], combinational from q
busy  output  1  sequence in progress
done  output  1  one-cycle pulse on sequence completion

Behaviour:
- Reset: while rst_n=0, immediately: q=0, busy=0, done=0, step counter=0, state=IDLE. This applies at any time, independent of clk.
- Mode encoding (one step):
  - 000 HOLD
  - 001 LOAD: q<=d
  - 010 SHL: q<={q[W-2:0],ser_in}
  - 011 SHR: q<={ser_in,q[W-1:1]}
  - 100 ROL: q<={q[W-2:0],q[W-1]}
  - 101 ROR: q<={q[0],q[W-1:1]}
  - 110 ASR: q<={q[W-1],q[W-1:1]}
  - 111 CLR: q<=0
- IDLE, en=1, start=0: apply one step of mode at each edge. done=0.
- IDLE, en=1, start=1, mode in 010..110:
  - At that edge: latch mode into op_r and amount into cnt; busy<=1; state<=RUN; q unchanged.
- IDLE, en=1, start=1, mode in 000/001/111:
  - Perform the single step at that edge; done<=1 at the same edge; busy stays 0.
- RUN, en=1, cnt>0:
  - Apply one op_r step; cnt<=cnt-1.
  - ser_in is sampled live at every step.
- RUN, en=1, cnt==0:
  - busy<=0, done<=1, state<=IDLE; q unchanged.
- Latency: a sequence with amount=N started at edge k gives busy=1 after edges k..k+N. At edge k+N+1, busy falls and done rises for exactly one cycle. amount=0 therefore gives busy for one cycle, then done, with q unchanged.
- done clears at the next edge with en=1. With en=0 it holds its value.
- While busy: mode, d, start and amount are ignored. A start arriving in the same cycle that done is high, in IDLE, is accepted normally, allowing back-to-back sequences.
- en=0: q, cnt, state, busy and done all hold. Steps resume when en returns to 1.
- amount greater than WIDTH is legal. Rotates wrap modulo WIDTH, shifts saturate to the fill pattern.
- Reset during RUN aborts the sequence. No done pulse is generated.

Test Plan:
- Reset and load: rst_n=0 mid-cycle with q=8'hA5 -> q=00 immediately, busy=0, done=0. Then LOAD d=8'h3C -> q=3C at the next edge.
- Single steps from q=8'h81: ROL -> 03; ROR -> 81 again; ASR -> C0; SHL with ser_in=1 -> 81 -> 03. CLR -> 00.
- Sequence: q=8'h96, start with mode=ROR, amount=3 -> q=D2 after 3 steps. busy high 4 cycles, done one cycle at edge k+4, then q holds D2.
- Edge counts: amount=0 -> busy 1 cycle, then done, q unchanged. ROL with amount=8 on 8'h5A -> q=5A. SHR with amount=10 and ser_in=0 on 8'hFF -> q=00.
- Pause and ignore: during an SHL sequence, deassert en for 2 cycles -> q, busy and cnt frozen, and total busy length extends by 2. Toggling mode/d/start while busy has no effect.
- Abort and back-to-back: reset mid-RUN -> q=0 and no done. A start held high through a completing sequence -> new sequence accepted in the cycle with done=1, and busy re-rises the following cycle.
